// File: rtl/display_pkg.sv
// Shared display definitions: BCD digit geometry, counter FSM encoding and
// the packed digit word that the number renderer also consumes.
package display_pkg;

   localparam int unsigned BCD_W  = 4;
   localparam int unsigned DIGITS = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_STEP    = 2'd1;
   localparam logic [1:0] ST_PUBLISH = 2'd2;

   typedef logic [DIGITS*BCD_W-1:0] bcd_word_t;

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit increment/decrement with carry (up) or borrow (down) out.
module bcd_digit_step
   import display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       dir,
   output logic [3:0] next,
   output logic       carry
);

   always_comb begin
      next  = digit;
      carry = 1'b0;
      if (dir) begin
         if (digit == BCD_MAX) begin
            next  = '0;
            carry = 1'b1;
         end else begin
            next = digit + 4'd1;
         end
      end else begin
         if (digit == '0) begin
            next  = BCD_MAX;
            carry = 1'b1;
         end else begin
            next = digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_frame_counter.sv
// Frame-paced 4-digit BCD up/down counter; ripples one digit per clock and
// publishes a stable snapshot with a one-cycle valid pulse.
module bcd_frame_counter
   import display_pkg::*;
#(
   parameter int unsigned FRAME_DIV = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        enable,
   input  logic        up,
   input  logic        clear,
   output logic [15:0] bcd,
   output logic        bcd_valid,
   output logic        wrap
);

   localparam logic [7:0] FCNT_LAST = 8'(FRAME_DIV - 1);

   logic [1:0]       state;
   logic [1:0]       idx;
   bcd_word_t        work;
   logic [7:0]       fcnt;
   logic             pending;
   logic             vs_q;
   logic             dir;
   logic             wrap_flag;
   logic             frame_start;
   logic             step_req;
   logic [BCD_W-1:0] cur_digit;
   logic [BCD_W-1:0] next_digit;
   logic             carry;

   assign frame_start = vs_q & ~vsync;
   assign step_req    = frame_start & enable & (fcnt == FCNT_LAST);
   assign cur_digit   = work[{idx, 2'b00} +: BCD_W];

   bcd_digit_step u_step (
      .digit (cur_digit),
      .dir   (dir),
      .next  (next_digit),
      .carry (carry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_q <= 1'b0;
      end else begin
         vs_q <= vsync;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fcnt <= '0;
      end else if (clear) begin
         fcnt <= '0;
      end else if (frame_start && enable) begin
         fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         work      <= '0;
         bcd       <= '0;
         bcd_valid <= 1'b0;
         wrap      <= 1'b0;
         pending   <= 1'b0;
         dir       <= 1'b1;
         wrap_flag <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         wrap      <= 1'b0;
         if (clear) begin
            work      <= '0;
            pending   <= 1'b0;
            wrap_flag <= 1'b0;
            state     <= ST_IDLE;
            bcd       <= '0;
            bcd_valid <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (step_req || pending) begin
                     dir     <= up;
                     idx     <= '0;
                     pending <= 1'b0;
                     state   <= ST_STEP;
                  end
               end
               ST_STEP: begin
                  if (step_req) pending <= 1'b1;
                  work[{idx, 2'b00} +: BCD_W] <= next_digit;
                  if (!carry) begin
                     state <= ST_PUBLISH;
                  end else if (idx == 2'd3) begin
                     wrap_flag <= 1'b1;
                     state     <= ST_PUBLISH;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
               ST_PUBLISH: begin
                  if (step_req) pending <= 1'b1;
                  bcd       <= work;
                  bcd_valid <= 1'b1;
                  wrap      <= wrap_flag;
                  wrap_flag <= 1'b0;
                  state     <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_frame_counter.sv
// Scoreboard bench: expected publishes (value, wrap, cycle) are queued when
// frames are driven and popped by a monitor when bcd_valid fires.
module tb_bcd_frame_counter;

   localparam int FD = 2;

   typedef struct packed {
      logic [15:0] bcd;
      logic        wrap;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vsync = 1'b0;
   logic        enable = 1'b1;
   logic        up = 1'b1;
   logic        clear = 1'b0;
   logic [15:0] bcd;
   logic        bcd_valid;
   logic        wrap;

   logic        vsync1 = 1'b1;
   logic        up1 = 1'b1;
   logic [15:0] bcd1;
   logic        bcd_valid1;
   logic        wrap1;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   mcount = 0;
   int   mfcnt = 0;
   ev_t  exp_q[$];
   ev_t  exp1_q[$];
   ev_t  got0;
   ev_t  got1;

   bcd_frame_counter #(.FRAME_DIV(FD)) u_dut (
      .clk(clk), .reset(reset), .vsync(vsync), .enable(enable), .up(up),
      .clear(clear), .bcd(bcd), .bcd_valid(bcd_valid), .wrap(wrap)
   );

   bcd_frame_counter #(.FRAME_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .vsync(vsync1), .enable(1'b1), .up(up1),
      .clear(1'b0), .bcd(bcd1), .bcd_valid(bcd_valid1), .wrap(wrap1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // number of digits that ripple before the step settles, at most 3
   function automatic int carries(int v, logic d);
      int k = 0;
      int t = v;
      bit go = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (go && ((d && t % 10 == 9) || (!d && t % 10 == 0))) begin
            k++;
            t = t / 10;
         end else begin
            go = 1'b0;
         end
      end
      return k;
   endfunction

   always @(negedge clk) begin
      if (reset && bcd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL publish_main unexpected bcd=%h wrap=%b cyc=%0d, no publish expected", bcd, wrap, cyc);
         end else begin
            got0 = exp_q.pop_front();
            if (bcd !== got0.bcd || wrap !== got0.wrap || cyc !== got0.cyc) begin
               errors++;
               $display("FAIL publish_main got bcd=%h wrap=%b cyc=%0d expected bcd=%h wrap=%b cyc=%0d",
                        bcd, wrap, cyc, got0.bcd, got0.wrap, got0.cyc);
            end
         end
      end
      if (reset && bcd_valid1) begin
         checks++;
         if (exp1_q.size() == 0) begin
            errors++;
            $display("FAIL publish_aux unexpected bcd=%h wrap=%b cyc=%0d, no publish expected", bcd1, wrap1, cyc);
         end else begin
            got1 = exp1_q.pop_front();
            if (bcd1 !== got1.bcd || wrap1 !== got1.wrap || cyc !== got1.cyc) begin
               errors++;
               $display("FAIL publish_aux got bcd=%h wrap=%b cyc=%0d expected bcd=%h wrap=%b cyc=%0d",
                        bcd1, wrap1, cyc, got1.bcd, got1.wrap, got1.cyc);
            end
         end
      end
   end

   task automatic frame();
      int   n;
      int   k;
      logic w;
      ev_t  e;
      @(posedge clk); #1 vsync = 1'b0;
      n = cyc;
      if (enable) begin
         if (mfcnt == FD - 1) begin
            mfcnt = 0;
            k = carries(mcount, up);
            if (up) begin
               w = (mcount == 9999);
               mcount = (mcount + 1) % 10000;
            end else begin
               w = (mcount == 0);
               mcount = (mcount + 9999) % 10000;
            end
            e.bcd = to_bcd(mcount);
            e.wrap = w;
            e.cyc = n + 3 + k;
            exp_q.push_back(e);
         end else begin
            mfcnt++;
         end
      end
      @(posedge clk); #1;
      @(posedge clk); #1 vsync = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic do_clear();
      ev_t e;
      @(posedge clk); #1 clear = 1'b1;
      e.bcd = 16'h0000;
      e.wrap = 1'b0;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      mcount = 0;
      mfcnt = 0;
      @(posedge clk); #1 clear = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h expected 0000", bcd); end
      checks++;
      if (bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bcd_valid); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b expected 0", wrap); end
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (bcd !== 16'h0000 || bcd_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got bcd=%h valid=%b expected 0000/0", bcd, bcd_valid);
      end
      checks++;
      if (bcd1 !== 16'h0000) begin errors++; $display("FAIL reset_aux got %h expected 0000", bcd1); end
   endtask

   task automatic test_first_step();
      up = 1'b1;
      repeat (3) frame();
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL first_step_pending got %0d outstanding expected 0", exp_q.size()); end
      checks++;
      if (bcd !== 16'h0001) begin errors++; $display("FAIL first_step_value got %h expected 0001", bcd); end
   endtask

   task automatic test_wrap();
      do_clear();
      up = 1'b0;
      repeat (2) frame();
      up = 1'b1;
      repeat (2) frame();
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending got %0d outstanding expected 0", exp_q.size()); end
      checks++;
      if (bcd !== 16'h0000) begin errors++; $display("FAIL wrap_value got %h expected 0000", bcd); end
   endtask

   task automatic test_enable();
      enable = 1'b0;
      repeat (10) frame();
      checks++;
      if (exp_q.size() != 0 || bcd !== 16'h0000) begin
         errors++;
         $display("FAIL enable_hold got bcd=%h outstanding=%0d expected 0000/0", bcd, exp_q.size());
      end
      enable = 1'b1;
      repeat (FD) frame();
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL enable_resume got %0d outstanding expected 0", exp_q.size()); end
      checks++;
      if (bcd !== 16'h0001) begin errors++; $display("FAIL enable_value got %h expected 0001", bcd); end
   endtask

   task automatic test_carry();
      do_clear();
      up = 1'b1;
      for (int i = 0; i < 999 * FD; i++) frame();
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (bcd !== 16'h0999) begin errors++; $display("FAIL preset_value got %h expected 0999", bcd); end
      repeat (FD) frame();
      up = 1'b0;
      repeat (FD) frame();
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL carry_pending got %0d outstanding expected 0", exp_q.size()); end
      checks++;
      if (bcd !== 16'h0999) begin errors++; $display("FAIL borrow_value got %h expected 0999", bcd); end
   endtask

   task automatic test_clear_mid_step();
      int  n;
      ev_t e;
      up = 1'b1;
      frame();
      @(posedge clk); #1 vsync = 1'b0;
      n = cyc;
      @(posedge clk); #1;
      @(posedge clk); #1 clear = 1'b1;
      vsync = 1'b1;
      e.bcd = 16'h0000;
      e.wrap = 1'b0;
      e.cyc = n + 3;
      exp_q.push_back(e);
      @(posedge clk); #1 clear = 1'b0;
      mcount = 0;
      mfcnt = 0;
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL clear_pulse got %0d outstanding expected 0", exp_q.size()); end
      checks++;
      if (bcd !== 16'h0000) begin errors++; $display("FAIL clear_value got %h expected 0000", bcd); end
   endtask

   task automatic test_back_to_back();
      int  n;
      ev_t e;
      up1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 vsync1 = 1'b0;
         if (i == 0) n = cyc;
         @(posedge clk); #1 vsync1 = 1'b1;
      end
      e.bcd = 16'h9999;
      e.wrap = 1'b1;
      e.cyc = n + 6;
      exp1_q.push_back(e);
      e.bcd = 16'h9998;
      e.wrap = 1'b0;
      e.cyc = n + 9;
      exp1_q.push_back(e);
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (exp1_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d outstanding expected 0", exp1_q.size()); end
      checks++;
      if (bcd1 !== 16'h9998) begin errors++; $display("FAIL b2b_value got %h expected 9998", bcd1); end
   endtask

   initial begin
      #1 reset = 1'b0;
      test_reset();
      test_first_step();
      test_wrap();
      test_enable();
      test_carry();
      test_clear_mid_step();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish, errors=%0d", errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
